// File: rtl/execute_alu_shift_arbiter_pkg.sv
// Shared definitions for the execute-stage shift arbiter.
// Holds the shift opcode encoding and the operand bundle that the grant mux selects.
package execute_alu_shift_arbiter_pkg;

  localparam logic [1:0] SHIFT_SLL = 2'b00;
  localparam logic [1:0] SHIFT_SRL = 2'b01;
  localparam logic [1:0] SHIFT_SRA = 2'b10;

  localparam int TAG_W_DEFAULT = 4;

  typedef struct packed {
    logic [31:0] d0;
    logic [4:0]  sa0;
    logic [4:0]  sa1;
    logic        sa_sel;
    logic [1:0]  sel;
  } shift_op_t;

endpackage

// File: rtl/execute_alu_impl_shift.sv
// Combinational 32-bit barrel shifter: SLL, SRL, SRA (sign-filled).
// The shift amount comes from either a register field or an immediate field.
module execute_alu_impl_shift
  import execute_alu_shift_arbiter_pkg::*;
(
  input  logic [31:0] d0,
  input  logic [4:0]  sa0,
  input  logic [4:0]  sa1,
  input  logic        sa_sel,
  input  logic [1:0]  sel,
  output logic [31:0] result
);

  logic [4:0] sa;

  assign sa = sa_sel ? sa1 : sa0;

  // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    result = d0 << sa;
    case (sel)
      SHIFT_SRL: result = d0 >> sa;
      SHIFT_SRA: result = $unsigned($signed(d0) >>> sa);
      default:   result = d0 << sa;
    endcase
  end

endmodule

// File: rtl/execute_alu_shift_arbiter.sv
// Round-robin arbiter sharing one barrel shifter between two ALU pipes.
// The result is held in one output register with a valid/ready handshake.
module execute_alu_shift_arbiter
  import execute_alu_shift_arbiter_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_d0,
  input  logic [4:0]       req0_sa0,
  input  logic [4:0]       req0_sa1,
  input  logic             req0_sa_sel,
  input  logic [1:0]       req0_sel,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_d0,
  input  logic [4:0]       req1_sa0,
  input  logic [4:0]       req1_sa1,
  input  logic             req1_sa_sel,
  input  logic [1:0]       req1_sel,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_src
);

  logic             rr;
  logic             accept;
  logic             grant_any;
  logic             grant_idx;
  shift_op_t        op0;
  shift_op_t        op1;
  shift_op_t        op_sel;
  logic [TAG_W-1:0] tag_sel;
  logic [31:0]      shift_result;

  assign accept = !flush && (!out_valid || out_ready);

  // With both pipes requesting the preferred one (rr) wins; otherwise the lone requester.
  always_comb begin
    grant_idx = 1'b0;
    if (req0_valid && req1_valid) grant_idx = rr;
    else if (req1_valid)          grant_idx = 1'b1;
  end

  assign grant_any  = !reset && accept && (req0_valid || req1_valid);
  assign req0_ready = grant_any && !grant_idx;
  assign req1_ready = grant_any &&  grant_idx;

  assign op0 = '{d0: req0_d0, sa0: req0_sa0, sa1: req0_sa1, sa_sel: req0_sa_sel, sel: req0_sel};
  assign op1 = '{d0: req1_d0, sa0: req1_sa0, sa1: req1_sa1, sa_sel: req1_sa_sel, sel: req1_sel};

  assign op_sel  = grant_idx ? op1 : op0;
  assign tag_sel = grant_idx ? req1_tag : req0_tag;

  execute_alu_impl_shift u_shift (
    .d0     (op_sel.d0),
    .sa0    (op_sel.sa0),
    .sa1    (op_sel.sa1),
    .sa_sel (op_sel.sa_sel),
    .sel    (op_sel.sel),
    .result (shift_result)
  );

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
      out_src   <= 1'b0;
      rr        <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      if (grant_any) begin
        out_valid <= 1'b1;
        out_data  <= shift_result;
        out_tag   <= tag_sel;
        out_src   <= grant_idx;
        rr        <= !grant_idx;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
